cpu_stack_ctl: RTL and testbench

CPU_STACK_CTL -- requirements
Module: cpu_stack_ctl

---
 rtl/cpu_stack_ctl.sv | 105 ++++++++++
 tb/tb_cpu_stack_ctl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_stack_ctl.sv
// Hardware stack controller: keeps the top entry in a register and spills the rest to a 1024x35 single-port RAM.
// Push and same-cycle pop+push take one cycle; a pop that must fetch a new top from RAM takes two.
// st__stall_5a is high during the single REFILL cycle, and request inputs are ignored while it is high.
module cpu_stack_ctl (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        st__pop_5a,
    input  logic [10:0] st__to_pop_5a,
    input  logic        st__push_5a,
    input  logic [34:0] st__to_push_5a,
    output logic        st__stall_5a,
    output logic [34:0] st__tos,
    output logic        st__tos_valid,
    output logic [10:0] st__depth,
    output logic        st__overflow,
    output logic        st__underflow,
    output logic [9:0]  ram_addr,
    output logic        ram_we,
    output logic [34:0] ram_wdata,
    output logic        ram_re,
    input  logic [34:0] ram_rdata
);

    typedef enum logic {IDLE, REFILL} state_t;

    localparam logic [10:0] FULL = 11'd1024;

    state_t state;
    logic   pop_act;
    logic   pop_lt;
    logic   pop_gt;

    assign pop_act       = st__pop_5a && (st__to_pop_5a != 11'd0);
    assign pop_lt        = st__to_pop_5a < st__depth;
    assign pop_gt        = st__to_pop_5a > st__depth;
    assign st__stall_5a  = (state == REFILL);
    assign st__tos_valid = (st__depth != 11'd0);

    // RAM strobes are issued in the same cycle as the accepted request.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = 10'd0;
        ram_wdata = 35'd0;
        if (state == IDLE) begin
            if (pop_act && !st__push_5a && pop_lt) begin
                ram_re   = 1'b1;
                ram_addr = 10'(st__depth - 11'd1 - st__to_pop_5a);
            end else if (!pop_act && st__push_5a &&
                         (st__depth != 11'd0) && (st__depth != FULL)) begin
                ram_we    = 1'b1;
                ram_addr  = 10'(st__depth - 11'd1);
                ram_wdata = st__tos;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state         <= IDLE;
            st__depth     <= 11'd0;
            st__tos       <= 35'd0;
            st__overflow  <= 1'b0;
            st__underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop_act && st__push_5a) begin
                        // Pop then push: the pushed value becomes the top and the
                        // entry underneath is already in RAM, so no access is needed.
                        st__tos <= st__to_push_5a;
                        if (pop_gt) begin
                            st__underflow <= 1'b1;
                            st__depth     <= 11'd1;
                        end else begin
                            st__depth <= st__depth - st__to_pop_5a + 11'd1;
                        end
                    end else if (pop_act) begin
                        if (pop_lt) begin
                            st__depth <= st__depth - st__to_pop_5a;
                            state     <= REFILL;
                        end else begin
                            st__depth <= 11'd0;
                            if (pop_gt)
                                st__underflow <= 1'b1;
                        end
                    end else if (st__push_5a) begin
                        if (st__depth == FULL) begin
                            st__overflow <= 1'b1;
                        end else begin
                            st__tos   <= st__to_push_5a;
                            st__depth <= st__depth + 11'd1;
                        end
                    end
                end
                REFILL: begin
                    st__tos <= ram_rdata;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_stack_ctl.sv
// Bench for cpu_stack_ctl: directed scenarios plus random traffic against a queue-based stack model and RAM image.
module tb_cpu_stack_ctl;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        st__pop_5a = 1'b0;
    logic [10:0] st__to_pop_5a = 11'd0;
    logic        st__push_5a = 1'b0;
    logic [34:0] st__to_push_5a = 35'd0;
    logic        st__stall_5a;
    logic [34:0] st__tos;
    logic        st__tos_valid;
    logic [10:0] st__depth;
    logic        st__overflow;
    logic        st__underflow;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [34:0] ram_wdata;
    logic        ram_re;
    logic [34:0] ram_rdata = 35'd0;

    logic [34:0] mem [0:1023];

    logic [34:0] stk[$];
    bit          m_ovf;
    bit          m_udf;
    int          errors = 0;
    int          checks = 0;

    cpu_stack_ctl dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .st__pop_5a    (st__pop_5a),
        .st__to_pop_5a (st__to_pop_5a),
        .st__push_5a   (st__push_5a),
        .st__to_push_5a(st__to_push_5a),
        .st__stall_5a  (st__stall_5a),
        .st__tos       (st__tos),
        .st__tos_valid (st__tos_valid),
        .st__depth     (st__depth),
        .st__overflow  (st__overflow),
        .st__underflow (st__underflow),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_re        (ram_re),
        .ram_rdata     (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        if (ram_re)
            ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] rnd35();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[34:0];
    endfunction

    task automatic idle_inputs();
        st__pop_5a     = 1'b0;
        st__to_pop_5a  = 11'd0;
        st__push_5a    = 1'b0;
        st__to_push_5a = 35'd0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".depth"}, 64'(st__depth), 64'(stk.size()));
        chk({tag, ".tos_valid"}, 64'(st__tos_valid), 64'(stk.size() != 0));
        if (stk.size() != 0)
            chk({tag, ".tos"}, 64'(st__tos), 64'(stk[$]));
        chk({tag, ".overflow"}, 64'(st__overflow), 64'(m_ovf));
        chk({tag, ".underflow"}, 64'(st__underflow), 64'(m_udf));
        chk({tag, ".stall"}, 64'(st__stall_5a), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".depth"}, 64'(st__depth), 64'd0);
        chk({tag, ".tos"}, 64'(st__tos), 64'd0);
        chk({tag, ".tos_valid"}, 64'(st__tos_valid), 64'd0);
        chk({tag, ".overflow"}, 64'(st__overflow), 64'd0);
        chk({tag, ".underflow"}, 64'(st__underflow), 64'd0);
        chk({tag, ".stall"}, 64'(st__stall_5a), 64'd0);
        chk({tag, ".ram_we"}, 64'(ram_we), 64'd0);
        chk({tag, ".ram_re"}, 64'(ram_re), 64'd0);
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_b = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        stk.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One request cycle (plus the refill cycle when the model predicts one); called at posedge+1.
    task automatic op(input string tag, input bit pop, input logic [10:0] n,
                      input bit push, input logic [34:0] d);
        int          sz;
        bit          pa;
        bit          e_we;
        bit          e_re;
        bit          refill;
        logic [9:0]  e_addr;
        logic [34:0] e_wd;
        sz     = stk.size();
        pa     = pop && (n != 11'd0);
        e_we   = 1'b0;
        e_re   = 1'b0;
        refill = 1'b0;
        e_addr = 10'd0;
        e_wd   = 35'd0;
        st__pop_5a     = pop;
        st__to_pop_5a  = n;
        st__push_5a    = push;
        st__to_push_5a = d;
        #1;
        if (pa && !push && int'(n) < sz) begin
            e_re   = 1'b1;
            e_addr = 10'(sz - 1 - int'(n));
            refill = 1'b1;
        end else if (!pa && push && sz >= 1 && sz <= 1023) begin
            e_we   = 1'b1;
            e_addr = 10'(sz - 1);
            e_wd   = stk[sz - 1];
        end
        chk({tag, ".ram_we"}, 64'(ram_we), 64'(e_we));
        chk({tag, ".ram_re"}, 64'(ram_re), 64'(e_re));
        chk({tag, ".ram_addr"}, 64'(ram_addr), 64'(e_addr));
        chk({tag, ".ram_wdata"}, 64'(ram_wdata), 64'(e_wd));
        chk({tag, ".stall_pre"}, 64'(st__stall_5a), 64'd0);
        if (pa) begin
            if (int'(n) > sz) begin
                m_udf = 1'b1;
                stk.delete();
            end else begin
                repeat (int'(n)) void'(stk.pop_back());
            end
        end
        if (push) begin
            if (stk.size() == 1024)
                m_ovf = 1'b1;
            else
                stk.push_back(d);
        end
        @(posedge clk);
        #1;
        if (refill) begin
            chk({tag, ".stall_refill"}, 64'(st__stall_5a), 64'd1);
            chk({tag, ".depth_refill"}, 64'(st__depth), 64'(stk.size()));
            // Junk requests during REFILL must be ignored.
            st__pop_5a     = 1'($urandom_range(0, 1));
            st__to_pop_5a  = 11'($urandom_range(0, 3));
            st__push_5a    = 1'($urandom_range(0, 1));
            st__to_push_5a = rnd35();
            #1;
            chk({tag, ".refill_we"}, 64'(ram_we), 64'd0);
            chk({tag, ".refill_re"}, 64'(ram_re), 64'd0);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        check_state(tag);
    endtask

    task automatic ram_image_check(input string tag);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < stk.size() - 1; i++)
            if (mem[i] !== stk[i])
                bad = 1'b1;
        chk({tag, ".ram_image"}, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [34:0] a, b, c, x;
        for (int i = 0; i < 1024; i++)
            mem[i] = 35'd0;
        a = 35'h1_1111_1111;
        b = 35'h2_2222_2222;
        c = 35'h3_3333_3333;
        #2;
        reset_dut();

        // Three pushes: A and B spill to RAM addresses 0 and 1.
        op("push_a", 0, 11'd0, 1, a);
        op("push_b", 0, 11'd0, 1, b);
        op("push_c", 0, 11'd0, 1, c);
        chk("abc.mem0", 64'(mem[0]), 64'(a));
        chk("abc.mem1", 64'(mem[1]), 64'(b));

        op("pop2", 1, 11'd2, 0, 35'd0);
        chk("pop2.tos_a", 64'(st__tos), 64'(a));

        op("rebuild_b", 0, 11'd0, 1, b);
        op("rebuild_c", 0, 11'd0, 1, c);
        op("pop1_push_d", 1, 11'd1, 1, 35'h4_4444_4444);
        op("pop0_noop", 1, 11'd0, 0, 35'd0);
        ram_image_check("directed");

        for (int i = 0; i < 300; i++) begin
            bit          p;
            bit          q;
            logic [10:0] n;
            p = ($urandom_range(0, 9) < 4);
            q = ($urandom_range(0, 2) != 0);
            n = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(0, 40)) : 11'($urandom_range(0, 3));
            op("random", p, n, q, rnd35());
            if (i % 50 == 49)
                ram_image_check("random");
        end

        reset_dut();
        while (stk.size() < 1024)
            op("fill", 0, 11'd0, 1, rnd35());
        ram_image_check("full");
        x = 35'h5_A5A5_A5A5;
        op("push_full", 0, 11'd0, 1, x);
        chk("push_full.ovf", 64'(st__overflow), 64'd1);
        op("ovf_sticky", 1, 11'd0, 0, 35'd0);
        op("pop_to_2", 1, 11'd1022, 0, 35'd0);
        op("pop5_under", 1, 11'd5, 0, 35'd0);
        chk("under.flag", 64'(st__underflow), 64'd1);
        op("push_y", 0, 11'd0, 1, 35'h6_0F0F_0F0F);
        op("pop_eq", 1, 11'd1, 0, 35'd0);
        op("popush_under", 1, 11'd3, 1, 35'h7_1234_5678);

        // Reset in the middle of a refill.
        reset_dut();
        op("r_push_a", 0, 11'd0, 1, a);
        op("r_push_b", 0, 11'd0, 1, b);
        op("r_push_c", 0, 11'd0, 1, c);
        st__pop_5a    = 1'b1;
        st__to_pop_5a = 11'd2;
        @(posedge clk);
        #1;
        chk("mid_refill.stall", 64'(st__stall_5a), 64'd1);
        idle_inputs();
        rst_b = 1'b0;
        #1;
        check_reset_outputs("mid_refill_reset");
        #2;
        rst_b = 1'b1;
        stk.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(posedge clk);
        #1;
        check_state("after_release");
        chk("after_release.tos", 64'(st__tos), 64'd0);
        op("after_release_push", 0, 11'd0, 1, c);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
